// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, ready flag values
// and the EX-side start/stop encoding.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_RUN    = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the partial
// remainder and keep the difference only when it does not go negative.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   partial,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0] diff;

  // The partial remainder is always below twice the divisor, so the sign of
  // the (DATA_W+1)-bit difference is exactly "partial < divisor".
  always_comb begin
    diff     = partial - {1'b0, divisor};
    q_bit    = ~diff[DATA_W];
    rem_next = q_bit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: accepts a request from EX, runs DATA_W restoring steps
// on operand magnitudes, applies the sign fixup and returns {rem, quot}.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_e          state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [DATA_W-1:0]   quo, quo_next;
  logic [DATA_W-1:0]   rem, rem_next;
  logic [DATA_W-1:0]   dvs, dvs_next;
  logic                sign_q, sign_q_next;
  logic                sign_r, sign_r_next;
  logic [2*DATA_W-1:0] result_next;
  logic                ready_next;
  logic                busy_next;

  logic [DATA_W-1:0]   step_rem;
  logic                step_q;
  logic [DATA_W-1:0]   final_quo;
  logic                abort;
  logic                accept;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

  // The dividend register doubles as the quotient: its MSB feeds the next
  // step while the new quotient bit enters at the LSB.
  div_step #(.DATA_W(DATA_W)) u_step (
    .partial  ({rem, quo[DATA_W-1]}),
    .divisor  (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign final_quo = {quo[DATA_W-2:0], step_q};
  assign abort     = annul_i || (start_i == DIV_STOP);
  assign accept    = (start_i == DIV_START) && !annul_i;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    quo_next    = quo;
    rem_next    = rem;
    dvs_next    = dvs;
    sign_q_next = sign_q;
    sign_r_next = sign_r;
    result_next = '0;
    ready_next  = DIV_RESULT_NOT_READY;

    case (state)
      DIV_IDLE: begin
        if (accept) begin
          if (opdata2_i == '0) begin
            state_next = DIV_BYZERO;
          end else begin
            quo_next    = magnitude(opdata1_i, signed_i);
            dvs_next    = magnitude(opdata2_i, signed_i);
            rem_next    = '0;
            sign_q_next = signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            sign_r_next = signed_i && opdata1_i[DATA_W-1];
            cnt_next    = '0;
            state_next  = DIV_RUN;
          end
        end
      end

      DIV_BYZERO: begin
        if (abort) begin
          state_next = DIV_IDLE;
        end else begin
          ready_next = DIV_RESULT_READY;
          state_next = DIV_DONE;
        end
      end

      DIV_RUN: begin
        if (abort) begin
          state_next = DIV_IDLE;
        end else begin
          quo_next = final_quo;
          rem_next = step_rem;
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            result_next = {sign_r ? -step_rem : step_rem,
                           sign_q ? -final_quo : final_quo};
            ready_next  = DIV_RESULT_READY;
            state_next  = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        if (abort) begin
          state_next = DIV_IDLE;
        end else begin
          result_next = result_o;
          ready_next  = DIV_RESULT_READY;
        end
      end

      default: state_next = DIV_IDLE;
    endcase

    busy_next = (state_next != DIV_IDLE);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // values computed from the previous cycle, independent of statement order.
  // NOTE: all datapath registers are reset too, so a reset mid-divide leaves no
  // stale operands visible on the outputs or in the next operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      quo      <= quo_next;
      rem      <= rem_next;
      dvs      <= dvs_next;
      sign_q   <= sign_q_next;
      sign_r   <= sign_r_next;
      result_o <= result_next;
      ready_o  <= ready_next;
      busy_o   <= busy_next;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: hand-computed quotient/remainder pairs, latency,
// divide-by-zero, abort, asynchronous reset and back-to-back operation.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_ctrl #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges are counted with the acceptance edge as 1; a normal divide is
  // ready after edge 33, divide-by-zero after edge 2.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int exp_lat, input logic scramble);
    int lat;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    annul_i   = 1'b0;
    start_i   = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (scramble && lat == 5) begin
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'h0000_0000;
        signed_i  = ~sgn;
      end
    end while (!ready_o && lat < 40);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp);
    tick();
    check({tag, "_hold"}, {63'd0, ready_o}, 64'd1);
    start_i = 1'b0;
    tick();
    check({tag, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    int  seen_ready;
    rst       = 1'b0;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    annul_i   = 1'b0;
    #12;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    rst = 1'b1;
    tick();

    do_div("divu_7_2",     1'b0, 32'd7,         32'd2,         64'h00000001_00000003, 33, 1'b0);
    do_div("div_m7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    do_div("div_7_m2",     1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33, 1'b0);
    do_div("divu_m7_2",    1'b0, 32'hFFFFFFF9,  32'd2,         64'h00000001_7FFFFFFC, 33, 1'b0);
    do_div("div_overflow", 1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33, 1'b0);
    do_div("divu_max_1",   1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 33, 1'b0);

    // Divide by zero: busy through cycles 1-2, ready after edge 2.
    signed_i  = 1'b1;
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    tick();
    check("byzero_c1_busy", {63'd0, busy_o}, 64'd1);
    check("byzero_c1_ready", {63'd0, ready_o}, 64'd0);
    tick();
    check("byzero_c2_busy", {63'd0, busy_o}, 64'd1);
    check("byzero_c2_ready", {63'd0, ready_o}, 64'd1);
    check("byzero_result", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    check("byzero_drop_ready", {63'd0, ready_o}, 64'd0);
    check("byzero_drop_busy", {63'd0, busy_o}, 64'd0);

    // Annul at step 10 of a running divide, then an immediate new request.
    signed_i   = 1'b0;
    opdata1_i  = 32'd1000;
    opdata2_i  = 32'd3;
    start_i    = 1'b1;
    seen_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready_o) seen_ready = 1;
    end
    check("annul_busy_before", {63'd0, busy_o}, 64'd1);
    annul_i = 1'b1;
    tick();
    if (ready_o) seen_ready = 1;
    check("annul_busy", {63'd0, busy_o}, 64'd0);
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    check("annul_result", result_o, 64'd0);
    tick();
    if (ready_o) seen_ready = 1;
    check("annul_no_ready", 64'(seen_ready), 64'd0);
    check("annul_priority", {63'd0, busy_o}, 64'd0);
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);

    // Asynchronous reset between edges during RUN.
    signed_i  = 1'b0;
    opdata1_i = 32'd12345;
    opdata2_i = 32'd11;
    start_i   = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, busy_o}, 64'd0);
    check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    start_i = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    check("rst_release_idle", {63'd0, busy_o}, 64'd0);

    // Back-to-back with one idle cycle between; the second also changes
    // operands mid-run, which must be ignored.
    do_div("div_m100_7",  1'b1, 32'hFFFFFF9C, 32'd7,  64'hFFFFFFFE_FFFFFFF2, 33, 1'b0);
    do_div("divu_1000_33", 1'b0, 32'd1000,    32'd33, 64'h0000000A_0000001E, 33, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle sequencer for the DIV/DIVU hi/lo path, replacing the single-cycle combinational `/` and `%` in the execute stage.
- Accepts a divide request from EX, runs a 32-step restoring division, and applies the sign fixup.
- Returns {remainder, quotient}, i.e. {hi, lo}, with a ready flag.
- EX raises stallreq while a divide op is present and ready_o is low. EX sends annul_i on pipeline flush.

Parameters:
- DATA_W, 32, operand width; counter width is clog2(DATA_W)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- start_i  in  1  divide requested; held high by EX until ready_o is seen.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend; sampled only on acceptance.
- opdata2_i  in  DATA_W  divisor; sampled only on acceptance.
- annul_i  in  1  abort current operation (flush or exception).
- result_o  out  2*DATA_W  {remainder[hi], quotient[lo]}.
- ready_o  out  1  result_o valid.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, result_o=0, ready_o=0, busy_o=0, internal dividend/remainder regs=0.
- States: IDLE, BYZERO, RUN, DONE. Registered outputs only.
- IDLE:
  - Acceptance is start_i=1 and annul_i=0.
  - On acceptance with opdata2_i==0: go to BYZERO.
  - On acceptance with a nonzero divisor:
    - latch |a| and |b| (magnitude only if signed_i, else raw);
    - latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB], both gated by signed_i;
    - cnt=0; go to RUN.
  - Otherwise stay in IDLE with ready_o=0.
- RUN:
  - One restoring step per cycle. The partial remainder is {rem, next dividend bit}; subtract the divisor.
  - If the difference is non-negative: keep it and shift in quotient bit 1. Else: keep the old value and shift in 0.
  - cnt increments each step. The step executed with cnt==DATA_W-1 is the last one.
  - On that same edge, register the sign-corrected result (negate quotient if sign_q; negate remainder if sign_r), set ready_o=1, and go to DONE.
- BYZERO: next edge sets result_o=0 (hi=0, lo=0), ready_o=1, and goes to DONE.
- DONE:
  - Hold result_o and ready_o=1 while start_i=1.
  - When start_i=0: go to IDLE, ready_o=0, result_o=0.
- Latency:
  - Normal divide: start accepted at edge E; ready_o goes high at edge E+DATA_W+1 (33 for DATA_W=32).
  - Divide by zero: ready_o goes high at E+2.
- Abort: annul_i=1, or start_i=0, in BYZERO, RUN or DONE forces IDLE on the next edge, with ready_o=0 and result_o=0. No result is produced.
  - annul_i has priority over acceptance in IDLE.
- Operand changes after acceptance are ignored.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is the natural wrap from the magnitude path; no trap.
- Back-to-back: a new divide requires start_i to drop for at least one cycle (DONE→IDLE) before re-acceptance.
- ready_o is never high in IDLE, RUN or BYZERO.

Decomposition:
- Shared constants go in consts.v:
  - state encodings `DIV_IDLE`, `DIV_BYZERO`, `DIV_RUN`, `DIV_DONE` (2 bits);
  - `DIV_RESULT_READY`, `DIV_RESULT_NOT_READY`;
  - `DIV_START`, `DIV_STOP` for the EX-side start/annul encoding.
- One combinational sub-module, div_step: inputs partial remainder (DATA_W+1) and divisor; outputs next remainder and quotient bit.
- Sign fixup and FSM stay in div_ctrl.

Test Plan:
- Unsigned divide: DIVU 7/2, hold start → ready_o at cycle 33, result_o = {0x00000001, 0x00000003}; drop start → ready_o=0 next cycle.
- Signed divide: DIV 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7 / 0xFFFFFFFE → q=0xFFFFFFFD, r=1.
- Divide by zero: DIV 5/0 → ready_o at cycle 2, result_o=0; busy_o high for cycles 1–2.
- Overflow: DIV 0x80000000/0xFFFFFFFF → q=0x80000000, r=0. DIVU 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
- Abort during RUN:
  - annul_i pulsed at step 10 → IDLE next edge, ready_o never rises;
  - immediate new DIVU 100/7 → q=14, r=2 after 33 cycles.
- Reset and back-to-back:
  - rst asserted mid-RUN (async, between edges) → outputs 0 immediately;
  - after release, two back-to-back divides separated by one idle cycle both return correct results.
  - Changing opdata1_i/opdata2_i during RUN does not affect the result.
